mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port SRAM (1-cycle read latency, ram_1p-style) between the Ibex instruction fetch port and the Ibex LSU data port.
- Address-decodes each request against the SRAM window and arbitrates round-robin with a last-grant register.
- Tracks response ownership and routes rvalid/rdata/err back to the correct requester.
- Out-of-window requests are granted and error-terminated locally and never reach the SRAM.

Parameters:
- MemStart, 32'h00000000, base address of SRAM window
- MemSize, 65536, window size in bytes; power of two, min 4
- DataFirst, 1'b1, round-robin tie-break owner coming out of reset (1 = data port first)

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous active-low reset
- instr_req_i  in  1  fetch request; held until granted
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch grant (combinational, same cycle)
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch bus error; qualified by rvalid
- data_req_i  in  1  LSU request; held until granted
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_addr_i  in  32  LSU byte address
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  LSU grant (combinational)
- data_rvalid_o  out  1  LSU response valid (reads and writes)
- data_rdata_o  out  32  LSU read data
- data_err_o  out  1  LSU bus error; qualified by rvalid
- mem_req_o  out  1  SRAM request
- mem_we_o  out  1  SRAM write
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  32  SRAM byte address, passed unmodified
- mem_wdata_o  out  32  SRAM write data
- mem_rvalid_i  in  1  SRAM response valid; exactly 1 cycle after mem_req_o
- mem_rdata_i  in  32  SRAM read data
- stat_instr_stall_o  out  32  cycles instr_req_i was high and not granted
- stat_data_stall_o  out  32  cycles data_req_i was high and not granted

Behaviour:
- Address decode: in_win = ((addr & ~(MemSize-1)) == MemStart).
- Arbitration:
  - At most one grant per cycle.
  - If only one requester is active, it is granted.
  - If both are active, the requester not granted last is granted.
  - last_q updates only on a grant.
  - Reset value of last_q = DataFirst ? instr : data, so the data port wins the first tie when DataFirst = 1.
- Issue on grant:
  - in_win: mem_req_o = 1, and the mem_* fields carry the winner's fields.
  - instr grant drives we = 0 and be = 4'hF.
  - Out-of-window: mem_req_o = 0.
- When not issuing, all mem_* outputs are 0 (no X or stale fields).
- Response pipeline registers: rsp_vld_q, rsp_own_q (0 = instr, 1 = data), rsp_err_q.
  - Each is loaded every cycle from (grant, winner, !in_win).
  - Fully pipelined: a new grant is allowed in the same cycle a response returns, so back-to-back throughput is 1 per cycle.
- Response routing, cycle N+1 after a grant in cycle N:
  - rvalid goes to the owner only.
  - rdata = mem_rdata_i when !rsp_err_q, 32'h0 when error.
  - err = rsp_err_q.
  - The non-owner's rvalid is 0 and its rdata is 0.
- Error case: the rvalid for an out-of-window access is generated internally, with mem_rvalid_i ignored.
- Protocol check (simulation assertion): mem_rvalid_i == (rsp_vld_q && !rsp_err_q).
- Latency: request → rvalid = 1 cycle when granted in its request cycle. A losing requester waits 1 extra cycle per lost arbitration, with a maximum of 1 loss because of round-robin.
- Reset (rst_ni low at a clock edge):
  - rsp_vld_q = 0 and last_q = its reset value.
  - All rvalid/err outputs = 0 the following cycle, and any in-flight response is dropped.
  - Grants are forced to 0 while rst_ni = 0.
  - Stat counters = 0.
- Stat counters saturate at 32'hFFFFFFFF; they do not wrap.

Optional Feature:
- Macro: MEM_PORT_ARBITER_STATS_EN.
- Defined: the stall counters are implemented as above.
- Undefined: no counter flops; stat_instr_stall_o and stat_data_stall_o tie to 32'h0. Ports are present in both builds.

Test Plan:
- Reset then data_req (we = 1, be = 4'h1, addr 0x10, wdata 0xA5) → data_gnt_o the same cycle, mem_req_o = 1 with mem_be_o = 4'h1; data_rvalid_o 1 cycle later with err = 0; instr_rvalid_o stays 0.
- instr and data both requesting continuously (in-window reads) from reset → grants alternate data, instr, data, instr…; each rvalid returns to the correct port with the matching mem_rdata_i; stat_instr_stall_o = 1 after the first conflict cycle.
- data_req to 0x0001_0000 (MemSize = 64 kB) → data_gnt_o = 1, mem_req_o = 0; next cycle data_rvalid_o = 1, data_err_o = 1, data_rdata_o = 0.
- instr fetch granted at cycle N, rst_ni low at N+1 → no instr_rvalid_o at N+1 or later; after reset release, first tie goes to data.
- Back-to-back instr fetches at 0x0, 0x4, 0x8 with no data traffic → 3 consecutive grants, 3 consecutive rvalids, no idle cycles.
- Force the stall counter near 32'hFFFFFFFE and keep instr starved for 3 cycles → counter holds at 32'hFFFFFFFF. With MEM_PORT_ARBITER_STATS_EN undefined → counter reads 0 throughout.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port SRAM (1-cycle read latency) between the
//            Ibex instruction-fetch port and the Ibex LSU data port. Requests
//            are decoded against the SRAM window and arbitrated round-robin.
//            Out-of-window requests are granted and error-terminated locally
//            without reaching the SRAM.
// Ports    : clk_i, rst_ni            clock, synchronous active-low reset
//            instr_*                  fetch request/grant/response channel
//            data_*                   LSU request/grant/response channel
//            mem_*                    SRAM request and response
//            stat_*_stall_o           saturating stall-cycle counters
// Options  : MEM_PORT_ARBITER_STATS_EN - when defined the stall counters are
//            built; otherwise both stat outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter logic [31:0] MemStart  = 32'h0000_0000,
   parameter int unsigned MemSize   = 65536,
   parameter bit          DataFirst = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   // Instruction fetch port
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   // LSU data port
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   // SRAM port
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   // Statistics
   output logic [31:0] stat_instr_stall_o,
   output logic [31:0] stat_data_stall_o
);

   localparam logic [31:0] WinMask  = ~(32'(MemSize) - 32'd1);
   localparam logic        OwnInstr = 1'b0;
   localparam logic        OwnData  = 1'b1;
   // last_q holds the previous winner; the other port wins the next tie.
   localparam logic        LastRst  = DataFirst ? OwnInstr : OwnData;

   logic        instr_in_win;
   logic        data_in_win;
   logic        gnt_instr;
   logic        gnt_data;
   logic        any_gnt;
   logic        win_in_win;
   logic        issue;
   logic        last_q;
   logic        rsp_vld_q;
   logic        rsp_own_q;
   logic        rsp_err_q;
   logic        rsp_live;
   logic [31:0] rsp_rdata;

   assign instr_in_win = ((instr_addr_i & WinMask) == MemStart);
   assign data_in_win  = ((data_addr_i  & WinMask) == MemStart);

   // Round-robin: on a tie the port that did not win last time is granted.
   always_comb begin
      gnt_data  = 1'b0;
      gnt_instr = 1'b0;
      if (rst_ni) begin
         if (data_req_i && (!instr_req_i || (last_q == OwnInstr))) begin
            gnt_data = 1'b1;
         end else if (instr_req_i) begin
            gnt_instr = 1'b1;
         end
      end
   end

   assign any_gnt     = gnt_instr | gnt_data;
   assign win_in_win  = gnt_data ? data_in_win : instr_in_win;
   assign issue       = any_gnt & win_in_win;
   assign instr_gnt_o = gnt_instr;
   assign data_gnt_o  = gnt_data;

   // SRAM request fields are zero whenever nothing is issued.
   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;
      if (issue) begin
         mem_req_o = 1'b1;
         if (gnt_data) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
         end else begin
            mem_we_o    = 1'b0;
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i;
            mem_wdata_o = 32'h0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         last_q <= LastRst;
      end else if (any_gnt) begin
         last_q <= gnt_data;
      end
   end

   // Response pipeline: one stage, reloaded every cycle so a new grant can
   // coincide with the response of the previous one.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rsp_vld_q <= 1'b0;
         rsp_own_q <= OwnInstr;
         rsp_err_q <= 1'b0;
      end else begin
         rsp_vld_q <= any_gnt;
         rsp_own_q <= gnt_data;
         rsp_err_q <= any_gnt & ~win_in_win;
      end
   end

   // Asserting reset drops an in-flight response immediately, not only from
   // the next cycle on.
   assign rsp_live  = rst_ni & rsp_vld_q;
   // Error responses never touched the SRAM, so its read data is ignored.
   assign rsp_rdata = rsp_err_q ? 32'h0 : mem_rdata_i;

   always_comb begin
      instr_rvalid_o = 1'b0;
      instr_rdata_o  = 32'h0;
      instr_err_o    = 1'b0;
      data_rvalid_o  = 1'b0;
      data_rdata_o   = 32'h0;
      data_err_o     = 1'b0;
      if (rsp_live) begin
         if (rsp_own_q == OwnData) begin
            data_rvalid_o = 1'b1;
            data_rdata_o  = rsp_rdata;
            data_err_o    = rsp_err_q;
         end else begin
            instr_rvalid_o = 1'b1;
            instr_rdata_o  = rsp_rdata;
            instr_err_o    = rsp_err_q;
         end
      end
   end

`ifdef MEM_PORT_ARBITER_STATS_EN
   logic [31:0] instr_stall_q;
   logic [31:0] data_stall_q;

   // Counters saturate at all-ones instead of wrapping.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         instr_stall_q <= 32'h0;
         data_stall_q  <= 32'h0;
      end else begin
         if (instr_req_i && !gnt_instr && (instr_stall_q != 32'hFFFF_FFFF)) begin
            instr_stall_q <= instr_stall_q + 32'd1;
         end
         if (data_req_i && !gnt_data && (data_stall_q != 32'hFFFF_FFFF)) begin
            data_stall_q <= data_stall_q + 32'd1;
         end
      end
   end

   assign stat_instr_stall_o = instr_stall_q;
   assign stat_data_stall_o  = data_stall_q;
`else
   assign stat_instr_stall_o = 32'h0;
   assign stat_data_stall_o  = 32'h0;
`endif

`ifndef SYNTHESIS
   // The SRAM must answer exactly the requests that were issued to it.
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert (mem_rvalid_i == (rsp_vld_q && !rsp_err_q));
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. A behavioural SRAM
//            answers issued requests; expected responses are queued when a
//            grant is observed and compared when the response cycle arrives.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

`ifdef MEM_PORT_ARBITER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic        instr_gnt;
   logic        instr_rvalid;
   logic [31:0] instr_rdata;
   logic        instr_err;
   logic        data_req;
   logic        data_we;
   logic [3:0]  data_be;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_gnt;
   logic        data_rvalid;
   logic [31:0] data_rdata;
   logic        data_err;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [31:0] stat_istall;
   logic [31:0] stat_dstall;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .instr_req_i        (instr_req),
      .instr_addr_i       (instr_addr),
      .instr_gnt_o        (instr_gnt),
      .instr_rvalid_o     (instr_rvalid),
      .instr_rdata_o      (instr_rdata),
      .instr_err_o        (instr_err),
      .data_req_i         (data_req),
      .data_we_i          (data_we),
      .data_be_i          (data_be),
      .data_addr_i        (data_addr),
      .data_wdata_i       (data_wdata),
      .data_gnt_o         (data_gnt),
      .data_rvalid_o      (data_rvalid),
      .data_rdata_o       (data_rdata),
      .data_err_o         (data_err),
      .mem_req_o          (mem_req),
      .mem_we_o           (mem_we),
      .mem_be_o           (mem_be),
      .mem_addr_o         (mem_addr),
      .mem_wdata_o        (mem_wdata),
      .mem_rvalid_i       (mem_rvalid),
      .mem_rdata_i        (mem_rdata),
      .stat_instr_stall_o (stat_istall),
      .stat_data_stall_o  (stat_dstall)
   );

   // Behavioural SRAM: 256 words, read-before-write, 1-cycle latency.
   logic [31:0] sram [0:255];
   always @(posedge clk) begin
      mem_rvalid <= rst_n ? mem_req : 1'b0;
      if (mem_req) begin
         mem_rdata <= sram[mem_addr[9:2]];
         if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_be[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
   end

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        own;   // 0 = instr, 1 = data
      logic        err;
      logic [31:0] data;
      int          cyc;
   } rsp_t;
   rsp_t sb[$];

   // Response monitor: pops the scoreboard entry due this cycle, if any.
   always @(negedge clk) begin
      rsp_t        e;
      logic        ev_i;
      logic        ev_d;
      logic        ee;
      logic [31:0] ed;
      #2;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         checks++; failures++;
         $display("FAIL rsp_missing cyc=%0d expected_at=%0d", cyc, e.cyc);
      end
      ev_i = 1'b0; ev_d = 1'b0; ee = 1'b0; ed = 32'h0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         ev_d = e.own; ev_i = ~e.own; ee = e.err; ed = e.data;
      end
      checks++;
      if (instr_rvalid !== ev_i) begin
         failures++; $display("FAIL instr_rvalid cyc=%0d got=%b exp=%b", cyc, instr_rvalid, ev_i);
      end
      checks++;
      if (data_rvalid !== ev_d) begin
         failures++; $display("FAIL data_rvalid cyc=%0d got=%b exp=%b", cyc, data_rvalid, ev_d);
      end
      checks++;
      if (instr_rdata !== (ev_i ? ed : 32'h0)) begin
         failures++; $display("FAIL instr_rdata cyc=%0d got=%h exp=%h", cyc, instr_rdata, ev_i ? ed : 32'h0);
      end
      checks++;
      if (data_rdata !== (ev_d ? ed : 32'h0)) begin
         failures++; $display("FAIL data_rdata cyc=%0d got=%h exp=%h", cyc, data_rdata, ev_d ? ed : 32'h0);
      end
      checks++;
      if (instr_err !== (ev_i & ee)) begin
         failures++; $display("FAIL instr_err cyc=%0d got=%b exp=%b", cyc, instr_err, ev_i & ee);
      end
      checks++;
      if (data_err !== (ev_d & ee)) begin
         failures++; $display("FAIL data_err cyc=%0d got=%b exp=%b", cyc, data_err, ev_d & ee);
      end
   end

   task automatic set_idle();
      instr_req  = 1'b0; instr_addr = 32'h0;
      data_req   = 1'b0; data_we    = 1'b0; data_be = 4'h0;
      data_addr  = 32'h0; data_wdata = 32'h0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      set_idle();
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         rst_n = 1'b0;
         instr_req = 1'b1; instr_addr = 32'h40;
         data_req  = 1'b1; data_addr  = 32'h80; data_be = 4'hF;
         #1;
         checks++;
         if ({instr_gnt, data_gnt, mem_req} !== 3'b000) begin
            failures++; $display("FAIL reset_gnt got=%b exp=000", {instr_gnt, data_gnt, mem_req});
         end
         checks++;
         if ({stat_istall, stat_dstall} !== 64'h0) begin
            failures++; $display("FAIL reset_stats got=%h/%h exp=0", stat_istall, stat_dstall);
         end
      end
      @(negedge clk);
      set_idle();
      rst_n = 1'b1;
   endtask

   task automatic test_single_write();
      logic [31:0] old;
      @(negedge clk);
      data_req = 1'b1; data_we = 1'b1; data_be = 4'h1;
      data_addr = 32'h10; data_wdata = 32'hA5;
      #1;
      old = sram[4];
      checks++;
      if ({data_gnt, instr_gnt, mem_req, mem_we} !== 4'b1011) begin
         failures++; $display("FAIL wr_gnt got=%b exp=1011", {data_gnt, instr_gnt, mem_req, mem_we});
      end
      checks++;
      if (mem_be !== 4'h1) begin
         failures++; $display("FAIL wr_be got=%h exp=1", mem_be);
      end
      checks++;
      if ({mem_addr, mem_wdata} !== {32'h10, 32'hA5}) begin
         failures++; $display("FAIL wr_fields got=%h/%h exp=10/a5", mem_addr, mem_wdata);
      end
      sb.push_back('{1'b1, 1'b0, old, cyc + 1});
      @(negedge clk);
      set_idle();
      @(negedge clk);
      #1;
      checks++;
      if (sram[4] !== {old[31:8], 8'hA5}) begin
         failures++; $display("FAIL wr_data got=%h exp=%h", sram[4], {old[31:8], 8'hA5});
      end
   endtask

   task automatic test_alternate();
      logic [31:0] ia;
      logic [31:0] da;
      logic [31:0] wa;
      logic        turn;
      do_reset();
      ia = 32'h100; da = 32'h200; turn = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         instr_req = 1'b1; instr_addr = ia;
         data_req  = 1'b1; data_we = 1'b0; data_be = 4'h3; data_addr = da;
         #1;
         wa = turn ? da : ia;
         checks++;
         if ({data_gnt, instr_gnt} !== {turn, ~turn}) begin
            failures++; $display("FAIL alt_gnt k=%0d got=%b exp=%b", k, {data_gnt, instr_gnt}, {turn, ~turn});
         end
         checks++;
         if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, turn ? 4'h3 : 4'hF, wa}) begin
            failures++; $display("FAIL alt_mem k=%0d got=%b/%h/%h exp_addr=%h", k, mem_we, mem_be, mem_addr, wa);
         end
         if (k == 1) begin
            checks++;
            if (stat_istall !== (STATS ? 32'd1 : 32'd0)) begin
               failures++; $display("FAIL alt_istall got=%0d exp=%0d", stat_istall, STATS ? 1 : 0);
            end
         end
         sb.push_back('{turn, 1'b0, sram[wa[9:2]], cyc + 1});
         if (turn) da = da + 32'd4; else ia = ia + 32'd4;
         turn = ~turn;
      end
      @(negedge clk);
      set_idle();
   endtask

   task automatic test_out_of_window();
      logic [31:0] addrs [4] = '{32'h0001_0000, 32'h0000_FFFC, 32'hFFFF_0000, 32'h0001_0004};
      logic        isd   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic        oow   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [31:0] a;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         set_idle();
         a = addrs[i];
         if (isd[i]) begin
            data_req = 1'b1; data_addr = a; data_be = 4'hF;
            data_we = (i == 0); data_wdata = 32'hDEAD_BEEF;
         end else begin
            instr_req = 1'b1; instr_addr = a;
         end
         #1;
         checks++;
         if ({data_gnt, instr_gnt} !== {isd[i], ~isd[i]}) begin
            failures++; $display("FAIL oow_gnt i=%0d got=%b exp=%b", i, {data_gnt, instr_gnt}, {isd[i], ~isd[i]});
         end
         checks++;
         if (mem_req !== ~oow[i]) begin
            failures++; $display("FAIL oow_memreq i=%0d got=%b exp=%b", i, mem_req, ~oow[i]);
         end
         if (oow[i]) begin
            checks++;
            if ({mem_we, mem_be, mem_addr, mem_wdata} !== 69'h0) begin
               failures++; $display("FAIL oow_fields i=%0d got=%b/%h/%h/%h exp=0", i, mem_we, mem_be, mem_addr, mem_wdata);
            end
         end
         sb.push_back('{isd[i], oow[i], oow[i] ? 32'h0 : sram[a[9:2]], cyc + 1});
      end
      @(negedge clk);
      set_idle();
   endtask

   task automatic test_reset_inflight();
      do_reset();
      @(negedge clk);
      instr_req = 1'b1; instr_addr = 32'h20;
      #1;
      checks++;
      if (instr_gnt !== 1'b1) begin
         failures++; $display("FAIL rin_gnt got=%b exp=1", instr_gnt);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         set_idle();
         rst_n = 1'b0;
         #1;
         checks++;
         if (instr_rvalid !== 1'b0) begin
            failures++; $display("FAIL rin_drop k=%0d got=%b exp=0", k, instr_rvalid);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      instr_req = 1'b1; instr_addr = 32'h24;
      data_req  = 1'b1; data_addr  = 32'h28; data_be = 4'hF;
      #1;
      checks++;
      if ({data_gnt, instr_gnt} !== 2'b10) begin
         failures++; $display("FAIL rin_tie got=%b exp=10", {data_gnt, instr_gnt});
      end
      sb.push_back('{1'b1, 1'b0, sram[10], cyc + 1});
      @(negedge clk);
      data_req = 1'b0;
      #1;
      checks++;
      if ({data_gnt, instr_gnt} !== 2'b01) begin
         failures++; $display("FAIL rin_next got=%b exp=01", {data_gnt, instr_gnt});
      end
      sb.push_back('{1'b0, 1'b0, sram[9], cyc + 1});
      @(negedge clk);
      set_idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a = 32'(i * 4);
         instr_req = 1'b1; instr_addr = a;
         #1;
         checks++;
         if ({instr_gnt, data_gnt, mem_req, mem_we, mem_be, mem_addr} !== {4'b1010, 4'hF, a}) begin
            failures++; $display("FAIL b2b i=%0d got=%b%b%b%b/%h/%h exp_addr=%h",
                                 i, instr_gnt, data_gnt, mem_req, mem_we, mem_be, mem_addr, a);
         end
         sb.push_back('{1'b0, 1'b0, sram[a[9:2]], cyc + 1});
      end
      @(negedge clk);
      set_idle();
   endtask

   task automatic test_stats();
      logic [31:0] exp_i;
      logic [31:0] exp_d;
      logic [31:0] wa;
      logic        turn;
      do_reset();
      exp_d = 32'h0;
`ifdef MEM_PORT_ARBITER_STATS_EN
      @(negedge clk);
      dut.instr_stall_q = 32'hFFFF_FFFE;
      exp_i = 32'hFFFF_FFFE;
`else
      exp_i = 32'h0;
`endif
      turn = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         instr_req = 1'b1; instr_addr = 32'h300;
         data_req  = 1'b1; data_addr  = 32'h304; data_be = 4'hF; data_we = 1'b0;
         #1;
         checks++;
         if (stat_istall !== exp_i) begin
            failures++; $display("FAIL stat_istall k=%0d got=%h exp=%h", k, stat_istall, exp_i);
         end
         checks++;
         if (stat_dstall !== exp_d) begin
            failures++; $display("FAIL stat_dstall k=%0d got=%h exp=%h", k, stat_dstall, exp_d);
         end
         wa = turn ? 32'h304 : 32'h300;
         sb.push_back('{turn, 1'b0, sram[wa[9:2]], cyc + 1});
         if (STATS) begin
            if (turn)  exp_i = (exp_i == 32'hFFFF_FFFF) ? exp_i : exp_i + 32'd1;
            else       exp_d = (exp_d == 32'hFFFF_FFFF) ? exp_d : exp_d + 32'd1;
         end
         turn = ~turn;
      end
      @(negedge clk);
      set_idle();
      #1;
      checks++;
      if (stat_istall !== exp_i) begin
         failures++; $display("FAIL stat_istall_end got=%h exp=%h", stat_istall, exp_i);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      set_idle();
      for (int i = 0; i < 256; i++) begin
         sram[i] = {8'hD0, 8'(i), ~8'(i), 8'h3C};
      end
      test_reset();
      test_single_write();
      test_alternate();
      test_out_of_window();
      test_reset_inflight();
      test_back_to_back();
      test_stats();
      repeat (2) @(negedge clk);
      #3;
      checks++;
      if (sb.size() != 0) begin
         failures++; $display("FAIL sb_drain left=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time=%0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
